aibcr3_dcc_dll_cal_seq: RTL and testbench
=========================================

# aibcr3_dcc_dll_cal_seq

Calibration sequencer for the AIB DCC/DLL pair. It drives `reinit`, `rb_dcc_byp` and `rb_cont_cal` into the DCC/DLL macro and waits for `dcc_done` and `odll_lock` in that order. It bounds each wait with a programmable timeout, retries a limited number of times, and reports a single calibrated/error status to the channel control logic. It sits between the channel CSR/adapter control and the DCC/DLL instance, in the `clk_pll` domain.

## Interface
- `SETTLE_CYC`, 16: cycles `reinit` is held asserted per attempt (≥2).
- `TMO_W`, 16: width of the timeout counter and of `cfg_tmo`.
- `RETRY_MAX`, 3: number of retries allowed after the first failed attempt.

Ports:
- `clk_pll`  in  1  sequencer clock.
- `nrst`  in  1  reset; one clock, reset is synchronous and active-low.
- `cal_start`  in  1  single-cycle calibration request.
- `cfg_dcc_byp`  in  1  skip the DCC phase; forwarded to `rb_dcc_byp`.
- `cfg_cont_cal`  in  1  continuous calibration enable; forwarded to `rb_cont_cal` only while LOCKED.
- `cfg_tmo`  in  TMO_W  per-phase timeout in cycles; 0 means no timeout.
- `dcc_done`  in  1  DCC converged; level, already synchronized to `clk_pll`.
- `odll_lock`  in  1  DLL lock; level, already synchronized.
- `reinit`  out  1  DCC/DLL re-initialize.
- `rb_dcc_byp`  out  1  registered copy of `cfg_dcc_byp`.
- `rb_cont_cal`  out  1  continuous calibration enable.
- `cal_busy`  out  1  sequence in progress.
- `cal_done`  out  1  calibrated and locked.
- `cal_err`  out  1  retries exhausted.
- `retry_cnt`  out  2  attempts failed in the current sequence (saturates at 3).

## Operation
- States:
  - IDLE: outputs quiet. `cal_start` → RESET.
  - RESET: `reinit`=1 for SETTLE_CYC cycles.
    - Next state is WAIT_LOCK if `rb_dcc_byp`=1, else WAIT_DCC.
  - WAIT_DCC: `dcc_done`=1 → WAIT_LOCK. Timeout → FAIL.
  - WAIT_LOCK: `odll_lock`=1 → LOCKED. Timeout → FAIL.
  - LOCKED: `cal_done`=1 and `rb_cont_cal`=`cfg_cont_cal`.
    - `odll_lock` falling → FAIL (lock loss).
    - `cal_start` → RESET, with `retry_cnt` cleared.
  - FAIL: one cycle, increments `retry_cnt`.
    - If attempts so far ≤ RETRY_MAX → RESET.
    - Else → ERR.
  - ERR: `cal_err`=1. Only `cal_start` exits → RESET, with `retry_cnt` cleared and `cal_err` cleared.
- Timeout counter:
  - Cleared on every state entry.
  - Increments each cycle in WAIT_DCC/WAIT_LOCK.
  - Timeout fires on the cycle count == `cfg_tmo`. `cfg_tmo`=0 disables it.
  - Counter saturates and never wraps.
- Settle counter: counts 0..SETTLE_CYC-1, then exits RESET.
- `rb_dcc_byp` is sampled from `cfg_dcc_byp` only on entry to RESET. It is stable for the whole attempt.
- `cal_start` while in RESET, WAIT_DCC, WAIT_LOCK or FAIL is ignored (no queuing).
- Simultaneous events:
  - Timeout and completion in the same cycle: completion wins.
  - Lock loss and `cal_start` in the same LOCKED cycle: `cal_start` wins and `retry_cnt` is cleared.
- `dcc_done` dropping during WAIT_LOCK is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `reinit`=0, `rb_dcc_byp`=0, `rb_cont_cal`=0.
  - `cal_busy`=0, `cal_done`=0, `cal_err`=0, `retry_cnt`=0.
  - Both counters 0.
- Reset asserted mid-sequence returns to IDLE on the next edge, with all outputs at reset values.
- All outputs are registered; no combinational path from input to output.
- `reinit` rises 1 cycle after `cal_start` is sampled and stays high exactly SETTLE_CYC cycles.
- `cal_busy`=1 in RESET/WAIT_DCC/WAIT_LOCK/FAIL, which covers the same cycles as `reinit` plus the wait states.
- Latency from inputs to `cal_done`:
  - `cal_done` rises 1 cycle after `odll_lock` is sampled high in WAIT_LOCK.
  - With `dcc_done` and `odll_lock` already high, `cal_start`→`cal_done` = SETTLE_CYC+3 cycles (bypass: SETTLE_CYC+2).
- `cal_done` and `rb_cont_cal` fall 1 cycle after lock loss is sampled.
- `reinit` re-rises 2 cycles after lock loss is sampled (via FAIL).

## Structure
- Shared package `aibcr3_dcc_dll_pkg`:
  - State enum `cal_state_t`: IDLE, RESET, WAIT_DCC, WAIT_LOCK, LOCKED, FAIL, ERR.
  - Default SETTLE_CYC/RETRY_MAX constants.
- One sub-module, `aibcr3_cal_tmo_cnt`: a saturating clear/enable counter with a compare-equal flag. It is instantiated twice, for settle and timeout.
- The FSM and output registers live in the top.

## Test plan
- Nominal: `cfg_dcc_byp`=0, `dcc_done` high 20 cycles after `cal_start`, `odll_lock` 30 cycles after that.
  - Expect `reinit` high 16 cycles, then `cal_done`=1, `retry_cnt`=0, `cal_err`=0.
- Bypass with `dcc_done` held 0, `odll_lock`=1: expect `cal_done` exactly 18 cycles after `cal_start`. WAIT_DCC is never entered.
- Timeout/retry with `cfg_tmo`=50 and `odll_lock` never rising: expect 4 `reinit` pulses, `retry_cnt` reaching 3, then `cal_err`=1 and `cal_busy`=0.
- Lock loss in LOCKED with `cfg_cont_cal`=1:
  - `odll_lock` drops → `cal_done`/`rb_cont_cal` =0 next cycle, `reinit` 2 cycles later, `retry_cnt`=1.
  - Lock returns → `cal_done`=1.
- Races:
  - `cal_start` during WAIT_LOCK is ignored.
  - `nrst` low in WAIT_DCC gives all outputs 0 next edge.
  - Timeout and `odll_lock` in the same cycle gives LOCKED.
  - `cfg_tmo`=0 waits 10k cycles with no FAIL.

Source files
------------

// File: rtl/aibcr3_dcc_dll_pkg.sv
// Shared types and defaults for the DCC/DLL calibration sequencer.
package aibcr3_dcc_dll_pkg;

   // Sequencer states, in the order a nominal calibration walks through them.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESET     = 3'd1,
      WAIT_DCC  = 3'd2,
      WAIT_LOCK = 3'd3,
      LOCKED    = 3'd4,
      FAIL      = 3'd5,
      ERR       = 3'd6
   } cal_state_t;

   // Default number of cycles reinit is held per attempt.
   localparam int SETTLE_CYC_DEF = 16;
   // Default timeout counter width.
   localparam int TMO_W_DEF      = 16;
   // Default number of retries after the first failed attempt.
   localparam int RETRY_MAX_DEF  = 3;

   // True for every state that belongs to an attempt in progress.
   function automatic logic is_busy(input cal_state_t s);
      return (s == RESET) || (s == WAIT_DCC) || (s == WAIT_LOCK) || (s == FAIL);
   endfunction

endpackage

// File: rtl/aibcr3_cal_tmo_cnt.sv
// Saturating up-counter with synchronous clear and a compare-equal flag.
// Used for both the reinit settle window and the per-phase timeout.
module aibcr3_cal_tmo_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] cmp_val,
   output logic         hit
);

   logic [W-1:0] cnt_reg;

   // Clear has priority over counting; the count parks at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en && (cnt_reg != '1)) begin
         cnt_reg <= cnt_reg + W'(1);
      end
   end

   assign hit = (cnt_reg == cmp_val);

endmodule

// File: rtl/aibcr3_dcc_dll_cal_seq.sv
// Calibration sequencer for the AIB DCC/DLL pair: pulses reinit, waits for
// dcc_done then odll_lock with a bounded timeout, retries a limited number of
// times and reports a single calibrated/error status. All outputs are
// registered decodes of the current state, so they trail the state by a cycle.
module aibcr3_dcc_dll_cal_seq
   import aibcr3_dcc_dll_pkg::*;
#(
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int TMO_W      = TMO_W_DEF,
   parameter int RETRY_MAX  = RETRY_MAX_DEF
) (
   input  logic             clk_pll,
   input  logic             nrst,
   input  logic             cal_start,
   input  logic             cfg_dcc_byp,
   input  logic             cfg_cont_cal,
   input  logic [TMO_W-1:0] cfg_tmo,
   input  logic             dcc_done,
   input  logic             odll_lock,
   output logic             reinit,
   output logic             rb_dcc_byp,
   output logic             rb_cont_cal,
   output logic             cal_busy,
   output logic             cal_done,
   output logic             cal_err,
   output logic [1:0]       retry_cnt
);

   // Settle counter only has to reach SETTLE_CYC-1.
   localparam int SETTLE_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

   // Failure counter must be able to hold RETRY_MAX+1 (the failure that gives up).
   localparam int FAIL_W = ($clog2(RETRY_MAX + 2) < 2) ? 2 : $clog2(RETRY_MAX + 2);
   localparam logic [FAIL_W-1:0] RETRY_LIM = FAIL_W'(RETRY_MAX);
   localparam logic [FAIL_W-1:0] RETRY_SAT = FAIL_W'(3);

   cal_state_t        state_reg;
   cal_state_t        state_next;
   logic              state_entry;
   logic              restart;
   logic              settle_done;
   logic              tmo_hit;
   logic              tmo_fire;
   logic              settle_en;
   logic              tmo_en;
   logic [FAIL_W-1:0] fail_cnt_reg;
   logic [FAIL_W-1:0] fail_cnt_next;

   logic              reinit_reg;
   logic              rb_dcc_byp_reg;
   logic              rb_cont_cal_reg;
   logic              cal_busy_reg;
   logic              cal_done_reg;
   logic              cal_err_reg;
   logic [1:0]        retry_cnt_reg;

   // Both counters restart from zero whenever the state changes.
   assign state_entry = (state_next != state_reg);
   assign settle_en   = (state_reg == RESET);
   assign tmo_en      = (state_reg == WAIT_DCC) || (state_reg == WAIT_LOCK);
   // A zero timeout value disables the timeout altogether.
   assign tmo_fire    = tmo_hit && (cfg_tmo != '0);

   aibcr3_cal_tmo_cnt #(
      .W (SETTLE_W)
   ) u_settle_cnt (
      .clk     (clk_pll),
      .nrst    (nrst),
      .clr     (state_entry),
      .en      (settle_en),
      .cmp_val (SETTLE_LAST),
      .hit     (settle_done)
   );

   aibcr3_cal_tmo_cnt #(
      .W (TMO_W)
   ) u_tmo_cnt (
      .clk     (clk_pll),
      .nrst    (nrst),
      .clr     (state_entry),
      .en      (tmo_en),
      .cmp_val (cfg_tmo),
      .hit     (tmo_hit)
   );

   // Next-state and failure-count logic; completion beats timeout, cal_start beats lock loss.
   always_comb begin
      state_next    = state_reg;
      restart       = 1'b0;
      fail_cnt_next = fail_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (cal_start) begin
               state_next = RESET;
               restart    = 1'b1;
            end
         end
         RESET: begin
            if (settle_done) begin
               state_next = rb_dcc_byp_reg ? WAIT_LOCK : WAIT_DCC;
            end
         end
         WAIT_DCC: begin
            if (dcc_done) begin
               state_next = WAIT_LOCK;
            end else if (tmo_fire) begin
               state_next = FAIL;
            end
         end
         WAIT_LOCK: begin
            if (odll_lock) begin
               state_next = LOCKED;
            end else if (tmo_fire) begin
               state_next = FAIL;
            end
         end
         LOCKED: begin
            if (cal_start) begin
               state_next = RESET;
               restart    = 1'b1;
            end else if (!odll_lock) begin
               state_next = FAIL;
            end
         end
         FAIL: begin
            fail_cnt_next = fail_cnt_reg + FAIL_W'(1);
            state_next    = (fail_cnt_next <= RETRY_LIM) ? RESET : ERR;
         end
         ERR: begin
            if (cal_start) begin
               state_next = RESET;
               restart    = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (restart) begin
         fail_cnt_next = '0;
      end
   end

   // State and failure-count registers.
   always_ff @(posedge clk_pll) begin
      if (!nrst) begin
         state_reg    <= IDLE;
         fail_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         fail_cnt_reg <= fail_cnt_next;
      end
   end

   // Bypass choice is latched once per attempt, at the edge that enters RESET.
   always_ff @(posedge clk_pll) begin
      if (!nrst) begin
         rb_dcc_byp_reg <= 1'b0;
      end else if ((state_next == RESET) && (state_reg != RESET)) begin
         rb_dcc_byp_reg <= cfg_dcc_byp;
      end
   end

   // Registered status outputs decoded from the current state.
   always_ff @(posedge clk_pll) begin
      if (!nrst) begin
         reinit_reg      <= 1'b0;
         rb_cont_cal_reg <= 1'b0;
         cal_busy_reg    <= 1'b0;
         cal_done_reg    <= 1'b0;
         cal_err_reg     <= 1'b0;
         retry_cnt_reg   <= 2'd0;
      end else begin
         reinit_reg      <= (state_reg == RESET);
         rb_cont_cal_reg <= (state_reg == LOCKED) && cfg_cont_cal;
         cal_busy_reg    <= is_busy(state_reg);
         cal_done_reg    <= (state_reg == LOCKED);
         cal_err_reg     <= (state_reg == ERR);
         retry_cnt_reg   <= (fail_cnt_next > RETRY_SAT) ? 2'd3 : fail_cnt_next[1:0];
      end
   end

   assign reinit      = reinit_reg;
   assign rb_dcc_byp  = rb_dcc_byp_reg;
   assign rb_cont_cal = rb_cont_cal_reg;
   assign cal_busy    = cal_busy_reg;
   assign cal_done    = cal_done_reg;
   assign cal_err     = cal_err_reg;
   assign retry_cnt   = retry_cnt_reg;

endmodule

// File: tb/tb_aibcr3_dcc_dll_cal_seq.sv
// Directed self-checking bench for the DCC/DLL calibration sequencer.
module tb_aibcr3_dcc_dll_cal_seq;

   logic        clk_pll;
   logic        nrst;
   logic        cal_start;
   logic        cfg_dcc_byp;
   logic        cfg_cont_cal;
   logic [15:0] cfg_tmo;
   logic        dcc_done;
   logic        odll_lock;
   logic        reinit;
   logic        rb_dcc_byp;
   logic        rb_cont_cal;
   logic        cal_busy;
   logic        cal_done;
   logic        cal_err;
   logic [1:0]  retry_cnt;
   logic [7:0]  outs;

   int checks = 0;
   int errors = 0;

   aibcr3_dcc_dll_cal_seq #(
      .SETTLE_CYC (16),
      .TMO_W      (16),
      .RETRY_MAX  (3)
   ) dut (
      .clk_pll      (clk_pll),
      .nrst         (nrst),
      .cal_start    (cal_start),
      .cfg_dcc_byp  (cfg_dcc_byp),
      .cfg_cont_cal (cfg_cont_cal),
      .cfg_tmo      (cfg_tmo),
      .dcc_done     (dcc_done),
      .odll_lock    (odll_lock),
      .reinit       (reinit),
      .rb_dcc_byp   (rb_dcc_byp),
      .rb_cont_cal  (rb_cont_cal),
      .cal_busy     (cal_busy),
      .cal_done     (cal_done),
      .cal_err      (cal_err),
      .retry_cnt    (retry_cnt)
   );

   assign outs = {reinit, rb_dcc_byp, rb_cont_cal, cal_busy, cal_done, cal_err, retry_cnt};

   initial clk_pll = 1'b0;
   always #5 clk_pll = ~clk_pll;

   // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk_pll);
      #1;
   endtask

   task automatic do_reset();
      nrst      = 1'b0;
      cal_start = 1'b0;
      tick();
      tick();
      nrst = 1'b1;
      tick();
   endtask

   // cal_start is sampled on the edge inside this task (edge E).
   task automatic pulse_start();
      cal_start = 1'b1;
      tick();
      cal_start = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      tick();
      tick();
      checks++;
      if (outs !== 8'h00) begin
         $display("FAIL reset_outputs: got %b expected %b", outs, 8'h00);
         errors++;
      end
      nrst = 1'b1;
      tick();
      tick();
      checks++;
      if (outs !== 8'h00) begin
         $display("FAIL idle_quiet: got %b expected %b", outs, 8'h00);
         errors++;
      end
   endtask

   task automatic test_nominal();
      int first_done = -1;
      int first_reinit = -1;
      int reinit_hi = 0;
      do_reset();
      cfg_dcc_byp = 1'b0; cfg_cont_cal = 1'b0; cfg_tmo = 16'd1000;
      dcc_done = 1'b0; odll_lock = 1'b0;
      pulse_start();
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (reinit) reinit_hi++;
         if (reinit && first_reinit < 0) first_reinit = n;
         if (cal_done && first_done < 0) first_done = n;
         if (n == 20) dcc_done = 1'b1;
         if (n == 50) odll_lock = 1'b1;
      end
      $display("nominal: reinit first=%0d high=%0d cal_done at %0d", first_reinit, reinit_hi, first_done);
      checks++;
      if (first_reinit !== 1) begin
         $display("FAIL nominal_reinit_rise: got %0d expected %0d", first_reinit, 1);
         errors++;
      end
      checks++;
      if (reinit_hi !== 16) begin
         $display("FAIL nominal_reinit_len: got %0d expected %0d", reinit_hi, 16);
         errors++;
      end
      checks++;
      if (first_done !== 52) begin
         $display("FAIL nominal_done_time: got %0d expected %0d", first_done, 52);
         errors++;
      end
      checks++;
      if ({cal_busy, cal_err, retry_cnt} !== 4'b0000) begin
         $display("FAIL nominal_status: got %b expected %b", {cal_busy, cal_err, retry_cnt}, 4'b0000);
         errors++;
      end
   endtask

   task automatic test_bypass();
      int first_done = -1;
      do_reset();
      cfg_dcc_byp = 1'b1; cfg_cont_cal = 1'b0; cfg_tmo = 16'd0;
      dcc_done = 1'b0; odll_lock = 1'b1;
      pulse_start();
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (cal_done && first_done < 0) first_done = n;
      end
      $display("bypass: cal_done at %0d rb_dcc_byp=%0b", first_done, rb_dcc_byp);
      checks++;
      if (first_done !== 18) begin
         $display("FAIL bypass_done_time: got %0d expected %0d", first_done, 18);
         errors++;
      end
      checks++;
      if (rb_dcc_byp !== 1'b1) begin
         $display("FAIL bypass_rb_dcc_byp: got %0b expected %0b", rb_dcc_byp, 1'b1);
         errors++;
      end
   endtask

   task automatic test_timeout_retry();
      int pulses = 0;
      logic prev = 1'b0;
      logic got_err = 1'b0;
      do_reset();
      cfg_dcc_byp = 1'b0; cfg_cont_cal = 1'b0; cfg_tmo = 16'd50;
      dcc_done = 1'b1; odll_lock = 1'b0;
      pulse_start();
      for (int n = 1; n <= 2000 && !got_err; n++) begin
         tick();
         if (reinit && !prev) pulses++;
         prev = reinit;
         if (cal_err) got_err = 1'b1;
      end
      $display("timeout: pulses=%0d retry_cnt=%0d cal_err=%0b cal_busy=%0b", pulses, retry_cnt, cal_err, cal_busy);
      checks++;
      if (got_err !== 1'b1) begin
         $display("FAIL timeout_err_reached: got %0b expected %0b", got_err, 1'b1);
         errors++;
      end
      checks++;
      if (pulses !== 4) begin
         $display("FAIL timeout_pulses: got %0d expected %0d", pulses, 4);
         errors++;
      end
      checks++;
      if ({cal_busy, retry_cnt} !== 3'b011) begin
         $display("FAIL timeout_status: got %b expected %b", {cal_busy, retry_cnt}, 3'b011);
         errors++;
      end
      // ERR only exits on cal_start, which clears the error and the retry count.
      pulse_start();
      tick();
      $display("err_exit: cal_err=%0b retry_cnt=%0d reinit=%0b", cal_err, retry_cnt, reinit);
      checks++;
      if ({cal_err, retry_cnt, reinit} !== 4'b0001) begin
         $display("FAIL err_exit: got %b expected %b", {cal_err, retry_cnt, reinit}, 4'b0001);
         errors++;
      end
   endtask

   task automatic test_lock_loss();
      logic locked = 1'b0;
      do_reset();
      cfg_dcc_byp = 1'b1; cfg_cont_cal = 1'b1; cfg_tmo = 16'd0;
      dcc_done = 1'b0; odll_lock = 1'b1;
      pulse_start();
      for (int n = 1; n <= 40 && !locked; n++) begin
         tick();
         if (cal_done) locked = 1'b1;
      end
      checks++;
      if ({cal_done, rb_cont_cal} !== 2'b11) begin
         $display("FAIL lock_cont_cal: got %b expected %b", {cal_done, rb_cont_cal}, 2'b11);
         errors++;
      end
      odll_lock = 1'b0;
      tick();
      tick();
      $display("lock_loss +1: cal_done=%0b rb_cont_cal=%0b reinit=%0b", cal_done, rb_cont_cal, reinit);
      checks++;
      if ({cal_done, rb_cont_cal, reinit} !== 3'b000) begin
         $display("FAIL lock_loss_plus1: got %b expected %b", {cal_done, rb_cont_cal, reinit}, 3'b000);
         errors++;
      end
      tick();
      $display("lock_loss +2: reinit=%0b retry_cnt=%0d", reinit, retry_cnt);
      checks++;
      if ({reinit, retry_cnt} !== 3'b101) begin
         $display("FAIL lock_loss_plus2: got %b expected %b", {reinit, retry_cnt}, 3'b101);
         errors++;
      end
      odll_lock = 1'b1;
      locked = 1'b0;
      for (int n = 1; n <= 40 && !locked; n++) begin
         tick();
         if (cal_done) locked = 1'b1;
      end
      checks++;
      if ({cal_done, retry_cnt} !== 3'b101) begin
         $display("FAIL lock_regained: got %b expected %b", {cal_done, retry_cnt}, 3'b101);
         errors++;
      end
      // Lock loss and cal_start together: the restart wins and clears retry_cnt.
      cal_start = 1'b1; odll_lock = 1'b0;
      tick();
      cal_start = 1'b0; odll_lock = 1'b1;
      tick();
      $display("loss_vs_start: retry_cnt=%0d reinit=%0b", retry_cnt, reinit);
      checks++;
      if ({retry_cnt, reinit} !== 3'b001) begin
         $display("FAIL loss_vs_start: got %b expected %b", {retry_cnt, reinit}, 3'b001);
         errors++;
      end
   endtask

   task automatic test_start_ignored();
      int first_done = -1;
      int reinit_hi = 0;
      do_reset();
      cfg_dcc_byp = 1'b1; cfg_cont_cal = 1'b0; cfg_tmo = 16'd0;
      dcc_done = 1'b0; odll_lock = 1'b0;
      pulse_start();
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (reinit) reinit_hi++;
         if (cal_done && first_done < 0) first_done = n;
         if (n == 20) cal_start = 1'b1;
         if (n == 21) cal_start = 1'b0;
         if (n == 30) odll_lock = 1'b1;
      end
      $display("start_ignored: reinit high=%0d cal_done at %0d", reinit_hi, first_done);
      checks++;
      if (reinit_hi !== 16) begin
         $display("FAIL start_ignored_reinit: got %0d expected %0d", reinit_hi, 16);
         errors++;
      end
      checks++;
      if (first_done !== 32) begin
         $display("FAIL start_ignored_done: got %0d expected %0d", first_done, 32);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cfg_dcc_byp = 1'b0; cfg_cont_cal = 1'b1; cfg_tmo = 16'd0;
      dcc_done = 1'b0; odll_lock = 1'b0;
      pulse_start();
      repeat (20) tick();
      checks++;
      if (cal_busy !== 1'b1) begin
         $display("FAIL reset_mid_busy: got %0b expected %0b", cal_busy, 1'b1);
         errors++;
      end
      nrst = 1'b0;
      tick();
      $display("reset_mid: outputs=%b", outs);
      checks++;
      if (outs !== 8'h00) begin
         $display("FAIL reset_mid_outputs: got %b expected %b", outs, 8'h00);
         errors++;
      end
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_tmo_race();
      logic locked = 1'b0;
      // Lock arrives on the same edge the timeout fires: lock wins.
      do_reset();
      cfg_dcc_byp = 1'b1; cfg_cont_cal = 1'b0; cfg_tmo = 16'd5;
      dcc_done = 1'b0; odll_lock = 1'b0;
      pulse_start();
      repeat (21) tick();
      odll_lock = 1'b1;
      for (int n = 1; n <= 40 && !locked; n++) begin
         tick();
         if (cal_done) locked = 1'b1;
      end
      $display("tmo_race same: cal_done=%0b retry_cnt=%0d", cal_done, retry_cnt);
      checks++;
      if ({cal_done, retry_cnt} !== 3'b100) begin
         $display("FAIL tmo_race_same: got %b expected %b", {cal_done, retry_cnt}, 3'b100);
         errors++;
      end
      // One edge later the timeout has already fired, costing one retry.
      do_reset();
      odll_lock = 1'b0;
      locked = 1'b0;
      pulse_start();
      repeat (22) tick();
      odll_lock = 1'b1;
      for (int n = 1; n <= 60 && !locked; n++) begin
         tick();
         if (cal_done) locked = 1'b1;
      end
      $display("tmo_race late: cal_done=%0b retry_cnt=%0d", cal_done, retry_cnt);
      checks++;
      if ({cal_done, retry_cnt} !== 3'b101) begin
         $display("FAIL tmo_race_late: got %b expected %b", {cal_done, retry_cnt}, 3'b101);
         errors++;
      end
   endtask

   task automatic test_no_tmo();
      int pulses = 0;
      logic prev = 1'b0;
      do_reset();
      cfg_dcc_byp = 1'b1; cfg_cont_cal = 1'b0; cfg_tmo = 16'd0;
      dcc_done = 1'b0; odll_lock = 1'b0;
      pulse_start();
      for (int n = 1; n <= 10000; n++) begin
         tick();
         if (reinit && !prev) pulses++;
         prev = reinit;
      end
      $display("no_tmo: pulses=%0d busy=%0b retry_cnt=%0d cal_err=%0b", pulses, cal_busy, retry_cnt, cal_err);
      checks++;
      if (pulses !== 1) begin
         $display("FAIL no_tmo_pulses: got %0d expected %0d", pulses, 1);
         errors++;
      end
      checks++;
      if ({cal_busy, cal_err, retry_cnt} !== 4'b1000) begin
         $display("FAIL no_tmo_status: got %b expected %b", {cal_busy, cal_err, retry_cnt}, 4'b1000);
         errors++;
      end
   endtask

   initial begin
      nrst = 1'b0; cal_start = 1'b0; cfg_dcc_byp = 1'b0; cfg_cont_cal = 1'b0;
      cfg_tmo = 16'd0; dcc_done = 1'b0; odll_lock = 1'b0;
      test_reset();
      test_nominal();
      test_bypass();
      test_timeout_retry();
      test_lock_loss();
      test_start_ignored();
      test_reset_mid();
      test_tmo_race();
      test_no_tmo();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
